out_period_data_gen_p: RTL and testbench
========================================

Name: out_period_data_gen_p

Overview:
Parametrised successor to the lighting-cycle period-data generator in the LEAP receiver BD.
- Captures the frame rate on each ov_stp strobe and clamps it to a 50 Hz or 60 Hz window.
- Scales the clamped rate, or takes a run-time fixed dividend, and divides it by the per-frame lighting-cycle count using an internal restoring divider.
- Produces the counter load values period_d and long_period_d, plus long_period_num, with an update strobe.
- Adds fixed-dividend mode, divide-by-zero detection, restart on a new strobe, and a busy/update handshake.

Parameters:
FR_W, 16, frame-rate and period_num width
PER_W, 12, period counter width
QUO_W, 28, dividend/quotient width (divider runs QUO_W iterations)
SCALE, 40940, frame-rate multiplier
SHIFT, 11, right shift applied to the product
F60_MIN, 20491, 60 Hz clamp low
F60_MAX, 21245, 60 Hz clamp high
F50_MIN, 24509, 50 Hz clamp low
F50_MAX, 25511, 50 Hz clamp high

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fr_rate  in  FR_W  frame count at 1.25 MHz
period_num  in  FR_W  lighting cycles per frame (divisor)
ov_stp  in  1  frame strobe, single-cycle
f50hz  in  1  1 = 50 Hz window, 0 = 60 Hz window
fix_en  in  1  1 = use fix_dat as dividend
fix_dat  in  QUO_W  fixed dividend
period_d  out  PER_W  period counter load value
long_period_d  out  PER_W  load value for the 1-clk-longer cycle
long_period_num  out  FR_W  number of long cycles per frame
busy  out  1  division in progress
upd  out  1  one-cycle pulse; outputs updated this cycle
div0  out  1  one-cycle pulse with upd when period_num was 0

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset: all outputs go to 0, the divider goes to IDLE, and the ov_stp delay line clears. A pending calculation is discarded with no upd.
- Pipeline, for ov_stp sampled at cycle T:
  - T+1: fr_rate_d <= fr_rate.
  - T+2: f60/f50 clamp. Values below MIN take MIN; values above MAX take MAX; boundary values pass unchanged.
  - T+3: select f50 or f60 by f50hz.
  - T+4: dividend <= fix_en ? fix_dat : (fr_dat*SCALE)>>SHIFT. The product is FR_W+16 bits; the result is zero-extended or truncated to QUO_W.
- Divider start: at T+5, the 5-cycle-delayed ov_stp loads the dividend and period_num.
- Divider FSM, IDLE -> RUN -> DONE -> IDLE:
  - RUN performs one restoring step per cycle for exactly QUO_W cycles; busy is high for exactly these cycles.
  - DONE lasts one cycle.
- Divide-by-zero: if period_num is 0 at load, the FSM skips RUN and goes straight to DONE. Quotient is forced to all ones, remainder to 0, and div0 is flagged.
- Restart: a start arriving in RUN or DONE aborts the current division and reloads with the new operands. Only the final result produces upd.
- Result registration, cycle after DONE:
  - period <= quotient, saturated to 2^PER_W-1 if any bit at or above PER_W is set.
  - rem <= remainder, low FR_W bits.
- Output registration, next cycle:
  - period_d <= sat(~period + 2), computed at PER_W+1 bits; all ones if it carries out.
  - long_period_d <= sat(~period + 1), same rule.
  - long_period_num <= rem.
  - upd pulses for one cycle; div0 pulses with upd when flagged.
- Latency: upd is asserted QUO_W+8 cycles after the ov_stp cycle (36 at default parameters), provided no restart occurs.
- Outputs hold their values between updates.
- fr_rate, period_num, fix_en and fix_dat need only be stable at their respective capture cycles.

Test Plan:
1. fix_en=1, fix_dat=585728, period_num=256, ov_stp -> upd 36 cycles later; period_d=0x711, long_period_d=0x710, long_period_num=0, div0=0.
2. fix_en=1, fix_dat=585728, period_num=300 -> quotient 1952 (0x7A0); period_d=0x861, long_period_d=0x860, long_period_num=128.
3. fix_en=0, f50hz=0, fr_rate=20000, so clamped to 20491 and dividend=409619; period_num=100 -> quotient 4096 saturates to 0xFFF; period_d=0x002, long_period_d=0x001, long_period_num=19.
4. period_num=0, any dividend -> div0 and upd pulse together; period_d=0x002, long_period_d=0x001, long_period_num=0; busy never asserts.
5. Second ov_stp 10 cycles after the first (in RUN), with a different period_num -> exactly one upd, carrying the second operands' result, 36 cycles after the second strobe.
6. rst asserted mid-RUN for one cycle -> busy drops the next cycle; no upd; all outputs read 0; a following ov_stp computes normally.

Source files
------------

// File: rtl/out_period_data_gen_p.sv
// -----------------------------------------------------------------------------
// out_period_data_gen_p
//
// Lighting-cycle period-data generator. On every frame strobe the measured
// frame rate is clamped into the selected 50 Hz / 60 Hz window and scaled into
// a dividend, or a fixed run-time dividend is used instead. The dividend is
// divided by the per-frame lighting-cycle count with a serial restoring
// divider. The quotient and remainder become the load values of the period
// counter.
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous reset, active-high
//   fr_rate         in   frame count at 1.25 MHz (FR_W)
//   period_num      in   lighting cycles per frame, the divisor (FR_W)
//   ov_stp          in   single-cycle frame strobe
//   f50hz           in   1 = 50 Hz clamp window, 0 = 60 Hz window
//   fix_en          in   1 = use fix_dat as the dividend
//   fix_dat         in   fixed dividend (QUO_W)
//   period_d        out  period counter load value (PER_W)
//   long_period_d   out  load value for the one-clock-longer cycle (PER_W)
//   long_period_num out  number of long cycles per frame (FR_W)
//   busy            out  high while the divider iterates
//   upd             out  one-cycle pulse, outputs changed this cycle
//   div0            out  one-cycle pulse alongside upd when period_num was 0
//
// Latency: upd rises QUO_W+8 cycles after the ov_stp cycle when no new strobe
// restarts the division. A strobe that reaches the divider while it is busy
// (or finishing) aborts the running division; only the last result is
// published.
// -----------------------------------------------------------------------------
module out_period_data_gen_p #(
  parameter int FR_W    = 16,
  parameter int PER_W   = 12,
  parameter int QUO_W   = 28,
  parameter int SCALE   = 40940,
  parameter int SHIFT   = 11,
  parameter int F60_MIN = 20491,
  parameter int F60_MAX = 21245,
  parameter int F50_MIN = 24509,
  parameter int F50_MAX = 25511
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FR_W-1:0]  fr_rate,
  input  logic [FR_W-1:0]  period_num,
  input  logic             ov_stp,
  input  logic             f50hz,
  input  logic             fix_en,
  input  logic [QUO_W-1:0] fix_dat,
  output logic [PER_W-1:0] period_d,
  output logic [PER_W-1:0] long_period_d,
  output logic [FR_W-1:0]  long_period_num,
  output logic             busy,
  output logic             upd,
  output logic             div0
);

  localparam int PROD_W = FR_W + 16;
  localparam int CNT_W  = $clog2(QUO_W + 1);

  localparam logic [FR_W-1:0]   F60_LO  = FR_W'(F60_MIN);
  localparam logic [FR_W-1:0]   F60_HI  = FR_W'(F60_MAX);
  localparam logic [FR_W-1:0]   F50_LO  = FR_W'(F50_MIN);
  localparam logic [FR_W-1:0]   F50_HI  = FR_W'(F50_MAX);
  localparam logic [PROD_W-1:0] SCALE_C = PROD_W'(SCALE);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(QUO_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Boundary values pass unchanged; only strictly outside values are pulled in.
  function automatic logic [FR_W-1:0] clamp_win(input logic [FR_W-1:0] v,
                                                input logic [FR_W-1:0] lo,
                                                input logic [FR_W-1:0] hi);
    logic [FR_W-1:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

  // Quotients that do not fit the period counter saturate to its maximum.
  function automatic logic [PER_W-1:0] sat_period(input logic [QUO_W-1:0] q);
    logic [PER_W-1:0] r;
    if ((q >> PER_W) != '0) r = '1;
    else                    r = PER_W'(q);
    return r;
  endfunction

  // Counter load value: one's complement of the period plus a small offset,
  // evaluated one bit wider so an overflow saturates instead of wrapping.
  function automatic logic [PER_W-1:0] sat_inv_add(input logic [PER_W-1:0] p,
                                                   input logic [1:0]       k);
    logic [PER_W:0]   s;
    logic [PER_W-1:0] r;
    s = {1'b0, ~p} + (PER_W + 1)'(k);
    if (s[PER_W]) r = '1;
    else          r = s[PER_W-1:0];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
  logic [FR_W-1:0]     fr_rate_p1;
  logic [FR_W-1:0]     f60_p2, f50_p2;
  logic [FR_W-1:0]     fr_dat_p3;
  logic [QUO_W-1:0]    dividend_p4;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [QUO_W-1:0]    dq_q;      // dividend shifting out / quotient shifting in
  logic [FR_W-1:0]     rem_q;
  logic [FR_W-1:0]     dvs_q;
  logic                dz_q;

  logic                res_vld_q;
  logic [PER_W-1:0]    period_q;
  logic [FR_W-1:0]     res_rem_q;
  logic                res_dz_q;

  logic [PER_W-1:0]    period_d_q;
  logic [PER_W-1:0]    long_period_d_q;
  logic [FR_W-1:0]     long_period_num_q;
  logic                upd_q;
  logic                div0_q;

  logic                start;
  logic                busy_c;
  logic                res_en;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   scaled;
  logic [FR_W:0]       rem_sh;
  logic [FR_W:0]       rem_sub;
  logic                step_ok;

  // ---------------------------------------------------------------------------
  // Strobe delay line (control, cleared by reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      vld_p5 <= 1'b0;
    end else begin
      vld_p1 <= ov_stp;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      vld_p5 <= vld_p4;
    end
  end

  assign start = vld_p5;

  // ---------------------------------------------------------------------------
  // Stage p1: capture frame rate on the strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ov_stp) fr_rate_p1 <= fr_rate;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: clamp into both windows
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      f60_p2 <= clamp_win(fr_rate_p1, F60_LO, F60_HI);
      f50_p2 <= clamp_win(fr_rate_p1, F50_LO, F50_HI);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p3: window select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (vld_p2) fr_dat_p3 <= f50hz ? f50_p2 : f60_p2;
  end

  // ---------------------------------------------------------------------------
  // Stage p4: dividend (scaled rate or fixed value)
  // ---------------------------------------------------------------------------
  assign prod   = PROD_W'(fr_dat_p3) * SCALE_C;
  assign scaled = prod >> SHIFT;

  always_ff @(posedge clk) begin
    if (vld_p3) dividend_p4 <= fix_en ? fix_dat : QUO_W'(scaled);
  end

  // ---------------------------------------------------------------------------
  // Divider FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a start always wins, which gives restart-on-new-strobe.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (period_num == '0) ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   state_d = (cnt_q == LAST_STEP) ? S_DONE : S_RUN;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy_c = 1'b0;
    res_en = 1'b0;
    unique case (state_q)
      S_RUN:   busy_c = 1'b1;
      S_DONE:  res_en = ~start;
      default: begin
        busy_c = 1'b0;
        res_en = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider datapath: one restoring step per RUN cycle
  // ---------------------------------------------------------------------------
  assign rem_sh  = {rem_q, dq_q[QUO_W-1]};
  assign step_ok = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (start) begin
      dvs_q <= period_num;
      rem_q <= '0;
      cnt_q <= '0;
      dz_q  <= (period_num == '0);
      // A zero divisor skips RUN, so the quotient register already holds
      // the forced all-ones result.
      dq_q  <= (period_num == '0) ? '1 : dividend_p4;
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      dq_q  <= {dq_q[QUO_W-2:0], step_ok};
      // The remainder is always below the divisor, so it fits FR_W bits.
      rem_q <= step_ok ? rem_sub[FR_W-1:0] : rem_sh[FR_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Result stage: saturated period and remainder
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) res_vld_q <= 1'b0;
    else     res_vld_q <= res_en;
  end

  always_ff @(posedge clk) begin
    if (res_en) begin
      period_q  <= sat_period(dq_q);
      res_rem_q <= rem_q;
      res_dz_q  <= dz_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: counter load values and update strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      period_d_q        <= '0;
      long_period_d_q   <= '0;
      long_period_num_q <= '0;
      upd_q             <= 1'b0;
      div0_q            <= 1'b0;
    end else begin
      upd_q  <= res_vld_q;
      div0_q <= res_vld_q & res_dz_q;
      if (res_vld_q) begin
        period_d_q        <= sat_inv_add(period_q, 2'd2);
        long_period_d_q   <= sat_inv_add(period_q, 2'd1);
        long_period_num_q <= res_rem_q;
      end
    end
  end

  assign period_d        = period_d_q;
  assign long_period_d   = long_period_d_q;
  assign long_period_num = long_period_num_q;
  assign upd             = upd_q;
  assign div0            = div0_q;
  assign busy            = busy_c;

endmodule

// File: tb/tb_out_period_data_gen_p.sv
module tb_out_period_data_gen_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fr_rate;
  logic [15:0] period_num;
  logic        ov_stp;
  logic        f50hz;
  logic        fix_en;
  logic [27:0] fix_dat;
  logic [11:0] period_d;
  logic [11:0] long_period_d;
  logic [15:0] long_period_num;
  logic        busy;
  logic        upd;
  logic        div0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  out_period_data_gen_p dut (
    .clk             (clk),
    .rst             (rst),
    .fr_rate         (fr_rate),
    .period_num      (period_num),
    .ov_stp          (ov_stp),
    .f50hz           (f50hz),
    .fix_en          (fix_en),
    .fix_dat         (fix_dat),
    .period_d        (period_d),
    .long_period_d   (long_period_d),
    .long_period_num (long_period_num),
    .busy            (busy),
    .upd             (upd),
    .div0            (div0)
  );

  typedef struct {
    logic        fix_en;
    logic [27:0] fix_dat;
    logic        f50hz;
    logic [15:0] fr_rate;
    logic [15:0] pn;
    logic [11:0] e_pd;
    logic [11:0] e_lpd;
    logic [15:0] e_lpn;
    logic        e_div0;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: clamp, scale, divide and complement with plain integers.
  task automatic model(input logic fe, input logic [27:0] fd, input logic f50,
                       input logic [15:0] fr, input logic [15:0] pn,
                       output vec_t v);
    longint lo, hi, c, dvd, q, r, per, pd, lpd;
    lo = f50 ? 24509 : 20491;
    hi = f50 ? 25511 : 21245;
    c  = (fr < lo) ? lo : ((fr > hi) ? hi : longint'(fr));
    dvd = fe ? longint'(fd) : (((c * 40940) / 2048) % (64'd1 << 28));
    if (pn == 0) begin
      q = (64'd1 << 28) - 1;
      r = 0;
    end else begin
      q = dvd / pn;
      r = dvd % pn;
    end
    per = (q > 4095) ? 4095 : q;
    pd  = 4097 - per; if (pd > 4095) pd = 4095;
    lpd = 4096 - per; if (lpd > 4095) lpd = 4095;
    v.fix_en = fe; v.fix_dat = fd; v.f50hz = f50; v.fr_rate = fr; v.pn = pn;
    v.e_pd = 12'(pd); v.e_lpd = 12'(lpd); v.e_lpn = 16'(r % 65536);
    v.e_div0 = (pn == 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k, bcnt;
    bit got;
    fix_en = v.fix_en; fix_dat = v.fix_dat; f50hz = v.f50hz;
    fr_rate = v.fr_rate; period_num = v.pn;
    ov_stp = 1'b1;
    k = 0; bcnt = 0; got = 0;
    while (k < 100 && !got) begin
      tick();
      ov_stp = 1'b0;
      k++;
      if (busy) bcnt++;
      if (upd) got = 1;
    end
    if (!got) begin
      chk({tag, "_upd_timeout"}, k, 36);
    end else begin
      if (!v.e_div0) chk({tag, "_latency"}, k, 36);
      chk({tag, "_busy_cycles"}, bcnt, v.e_div0 ? 0 : 28);
      chk({tag, "_period_d"}, period_d, v.e_pd);
      chk({tag, "_long_period_d"}, long_period_d, v.e_lpd);
      chk({tag, "_long_period_num"}, long_period_num, v.e_lpn);
      chk({tag, "_div0"}, div0, v.e_div0);
      tick();
      chk({tag, "_upd_pulse"}, upd, 0);
      chk({tag, "_hold"}, period_d, v.e_pd);
    end
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int k, nupd, upd_k;

    // fix_en, fix_dat, f50hz, fr_rate, pn, period_d, long_period_d, lpn, div0
    tbl[0] = '{1'b1, 28'd585728, 1'b0, 16'd0,     16'd256,  12'h711, 12'h710, 16'd0,   1'b0};
    tbl[1] = '{1'b1, 28'd585728, 1'b0, 16'd0,     16'd300,  12'h861, 12'h860, 16'd128, 1'b0};
    tbl[2] = '{1'b0, 28'd0,      1'b0, 16'd20000, 16'd100,  12'h002, 12'h001, 16'd19,  1'b0};
    tbl[3] = '{1'b1, 28'd12345,  1'b0, 16'd0,     16'd0,    12'h002, 12'h001, 16'd0,   1'b1};
    tbl[4] = '{1'b0, 28'd0,      1'b1, 16'd30000, 16'd1000, 12'hE04, 12'hE03, 16'd970, 1'b0};
    tbl[5] = '{1'b0, 28'd0,      1'b0, 16'd21245, 16'd200,  12'h7B6, 12'h7B5, 16'd92,  1'b0};
    tbl[6] = '{1'b1, 28'd100,    1'b0, 16'd0,     16'd1000, 12'hFFF, 12'hFFF, 16'd100, 1'b0};
    tbl[7] = '{1'b0, 28'd0,      1'b1, 16'd0,     16'd0,    12'h002, 12'h001, 16'd0,   1'b1};

    rst = 1'b1; ov_stp = 1'b0; fr_rate = '0; period_num = '0;
    f50hz = 1'b0; fix_en = 1'b0; fix_dat = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_period_d", period_d, 0);
    chk("rst_long_period_d", long_period_d, 0);
    chk("rst_long_period_num", long_period_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd, 0);
    chk("rst_div0", div0, 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
      repeat (2) tick();
    end

    // Restart: second strobe 10 cycles after the first, new divisor.
    fix_en = 1'b1; fix_dat = 28'd585728; period_num = 16'd256;
    ov_stp = 1'b1;
    k = 0; nupd = 0; upd_k = 0;
    while (k < 70) begin
      tick();
      ov_stp = 1'b0;
      k++;
      if (k == 10) begin
        period_num = 16'd300;
        ov_stp = 1'b1;
      end
      if (upd) begin
        nupd++;
        upd_k = k;
        chk("restart_period_d", period_d, 12'h861);
        chk("restart_long_period_d", long_period_d, 12'h860);
        chk("restart_long_period_num", long_period_num, 128);
      end
    end
    chk("restart_upd_count", nupd, 1);
    chk("restart_upd_cycle", upd_k, 46);

    // Reset in the middle of RUN.
    fix_en = 1'b1; fix_dat = 28'd585728; period_num = 16'd256;
    ov_stp = 1'b1;
    tick();
    ov_stp = 1'b0;
    repeat (14) tick();
    chk("midrun_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_busy", busy, 0);
    chk("midrun_upd", upd, 0);
    chk("midrun_period_d", period_d, 0);
    chk("midrun_long_period_d", long_period_d, 0);
    chk("midrun_long_period_num", long_period_num, 0);
    chk("midrun_div0", div0, 0);
    nupd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (upd || busy) nupd++;
    end
    chk("midrun_no_activity", nupd, 0);
    run_vec(tbl[1], "after_rst");
    repeat (2) tick();

    // Randomised operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] fr, pn;
      logic [2:0]  sel;
      sel = 3'($urandom_range(0, 7));
      fr = (sel < 3) ? 16'($urandom_range(20000, 26000)) : 16'($urandom);
      case (sel)
        3'd0:    pn = 16'd0;
        3'd1:    pn = 16'($urandom_range(1, 8));
        3'd2:    pn = 16'hFFFF;
        default: pn = 16'($urandom_range(1, 3000));
      endcase
      model(1'($urandom), 28'($urandom), 1'($urandom), fr, pn, v);
      run_vec(v, $sformatf("rnd%0d", i));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
